// File: rtl/riscv_pkg.sv
// Shared fetch-stage types: sequencer states, next-pc selector codes and the boot address.
package riscv_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    HALT
  } pc_state_t;

  typedef enum logic [2:0] {
    SEL_TRAP,
    SEL_RET,
    SEL_BRANCH,
    SEL_MISALIGN,
    SEL_HOLD,
    SEL_SEQ
  } pc_sel_t;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'hBFC00000;

endpackage

// File: rtl/pc_next_sel.sv
// Combinational priority encoder choosing the next fetch address while running.
import riscv_pkg::*;

module pc_next_sel #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int ALIGN_BITS    = 2
) (
  input  logic                     trap,
  input  logic                     ret,
  input  logic                     pc_branch,
  input  logic                     stall,
  input  logic [ADDRESS_WIDTH-1:0] pc,
  input  logic [ADDRESS_WIDTH-1:0] pc_target,
  input  logic [ADDRESS_WIDTH-1:0] trap_vector,
  input  logic [ADDRESS_WIDTH-1:0] epc,
  output pc_sel_t                  sel,
  output logic [ADDRESS_WIDTH-1:0] next_pc
);

  localparam logic [ADDRESS_WIDTH-1:0] STEP       = ADDRESS_WIDTH'(1) << ALIGN_BITS;
  localparam logic [ADDRESS_WIDTH-1:0] ALIGN_MASK = STEP - ADDRESS_WIDTH'(1);

  logic misaligned;

  assign misaligned = (pc_target & ALIGN_MASK) != '0;

  // Redirects outrank stall, so a stalled cycle can still be redirected.
  always_comb begin
    sel     = SEL_SEQ;
    next_pc = pc + STEP;
    if (trap) begin
      sel     = SEL_TRAP;
      next_pc = trap_vector;
    end else if (ret) begin
      sel     = SEL_RET;
      next_pc = epc;
    end else if (pc_branch && !misaligned) begin
      sel     = SEL_BRANCH;
      next_pc = pc_target;
    end else if (pc_branch) begin
      sel     = SEL_MISALIGN;
      next_pc = trap_vector;
    end else if (stall) begin
      sel     = SEL_HOLD;
      next_pc = pc;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-address generator: run/halt FSM, trap/return redirection with saved epc,
// misaligned-branch trapping and a retired-fetch counter.
import riscv_pkg::*;

module pc_sequencer #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_VECTOR  = ADDRESS_WIDTH'(DEFAULT_RESET_VECTOR),
  parameter int                       ALIGN_BITS    = 2,
  parameter int                       COUNT_WIDTH   = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     trigger,
  input  logic                     halt,
  input  logic                     stall,
  input  logic                     pc_branch,
  input  logic [ADDRESS_WIDTH-1:0] pc_target,
  input  logic                     trap,
  input  logic [ADDRESS_WIDTH-1:0] trap_pc,
  input  logic [ADDRESS_WIDTH-1:0] trap_vector,
  input  logic                     ret,
  output logic [ADDRESS_WIDTH-1:0] pc,
  output logic                     pc_valid,
  output logic [ADDRESS_WIDTH-1:0] epc,
  output logic                     misalign,
  output logic [COUNT_WIDTH-1:0]   fetch_count
);

  pc_state_t                state;
  pc_state_t                state_next;
  pc_sel_t                  sel;
  logic [ADDRESS_WIDTH-1:0] sel_pc;
  logic [ADDRESS_WIDTH-1:0] pc_d;
  logic [ADDRESS_WIDTH-1:0] epc_d;
  logic                     count_inc;
  logic                     misalign_d;

  pc_next_sel #(
    .ADDRESS_WIDTH(ADDRESS_WIDTH),
    .ALIGN_BITS   (ALIGN_BITS)
  ) u_next_sel (
    .trap       (trap),
    .ret        (ret),
    .pc_branch  (pc_branch),
    .stall      (stall),
    .pc         (pc),
    .pc_target  (pc_target),
    .trap_vector(trap_vector),
    .epc        (epc),
    .sel        (sel),
    .next_pc    (sel_pc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Dropping trigger wins over everything; a trap also overrides halt.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (trigger) state_next = RUN;
      RUN: begin
        if (!trigger)    state_next = IDLE;
        else if (!trap && halt) state_next = HALT;
      end
      HALT: begin
        if (!trigger)            state_next = IDLE;
        else if (trap || !halt)  state_next = RUN;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pc_valid   = (state == RUN);
    pc_d       = pc;
    epc_d      = epc;
    count_inc  = 1'b0;
    misalign_d = 1'b0;
    case (state)
      RUN: begin
        if (!trigger) begin
          pc_d = RESET_VECTOR;
        end else if (trap || !halt) begin
          pc_d      = sel_pc;
          count_inc = (sel != SEL_HOLD);
          if (sel == SEL_TRAP) epc_d = trap_pc;
          if (sel == SEL_MISALIGN) begin
            epc_d      = pc_target;
            misalign_d = 1'b1;
          end
        end
      end
      HALT: begin
        if (!trigger) begin
          pc_d = RESET_VECTOR;
        end else if (trap) begin
          pc_d  = trap_vector;
          epc_d = trap_pc;
        end
      end
      default: pc_d = RESET_VECTOR;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_VECTOR;
      epc         <= '0;
      misalign    <= 1'b0;
      fetch_count <= '0;
    end else begin
      pc       <= pc_d;
      epc      <= epc_d;
      misalign <= misalign_d;
      if (count_inc) fetch_count <= fetch_count + COUNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed vector table, hand sequences, random vs model.
module tb_pc_sequencer;

  localparam logic [31:0] RV = 32'hBFC00000;
  localparam logic [31:0] TV = 32'hBFC00200;
  localparam logic I = 1'b1;
  localparam logic O = 1'b0;

  logic        clk = 1'b0;
  logic        rst;
  logic        trigger, halt, stall, pc_branch, trap, ret;
  logic [31:0] pc_target, trap_pc, trap_vector;
  logic [31:0] pc, epc, fetch_count;
  logic        pc_valid, misalign;

  int tests = 0;
  int failures = 0;

  // Reference model state, expressed as "running" / "halted" flags.
  bit          m_active, m_halted, m_mis;
  logic [31:0] m_pc, m_epc, m_count;

  typedef struct packed {
    logic        trigger, halt, stall, pc_branch;
    logic [31:0] pc_target;
    logic        trap;
    logic [31:0] trap_pc;
    logic        ret;
    logic [31:0] exp_pc;
    logic        exp_valid;
    logic [31:0] exp_epc;
    logic        exp_mis;
    logic [31:0] exp_count;
  } vec_t;

  vec_t vecs[20];

  pc_sequencer dut (
    .clk(clk), .rst(rst), .trigger(trigger), .halt(halt), .stall(stall),
    .pc_branch(pc_branch), .pc_target(pc_target), .trap(trap), .trap_pc(trap_pc),
    .trap_vector(trap_vector), .ret(ret), .pc(pc), .pc_valid(pc_valid), .epc(epc),
    .misalign(misalign), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 0; m_halted = 0; m_mis = 0;
    m_pc = RV; m_epc = 32'h0; m_count = 32'h0;
  endtask

  task automatic model_step();
    m_mis = 0;
    if (!m_active) begin
      m_pc = RV;
      if (trigger) begin m_active = 1; m_halted = 0; end
    end else if (!trigger) begin
      m_active = 0; m_halted = 0; m_pc = RV;
    end else if (m_halted) begin
      if (trap) begin m_pc = trap_vector; m_epc = trap_pc; m_halted = 0; end
      else if (!halt) m_halted = 0;
    end else if (trap) begin
      m_pc = trap_vector; m_epc = trap_pc; m_count++;
    end else if (halt) begin
      m_halted = 1;
    end else if (ret) begin
      m_pc = m_epc; m_count++;
    end else if (pc_branch) begin
      if (pc_target % 4 != 0) begin
        m_epc = pc_target; m_pc = trap_vector; m_mis = 1;
      end else begin
        m_pc = pc_target;
      end
      m_count++;
    end else if (!stall) begin
      m_pc = m_pc + 32'd4; m_count++;
    end
  endtask

  task automatic applyStimulus(input logic tg, input logic h, input logic s, input logic b,
                               input logic [31:0] tgt, input logic tr, input logic [31:0] tpc,
                               input logic [31:0] tv, input logic r);
    trigger = tg; halt = h; stall = s; pc_branch = b; pc_target = tgt;
    trap = tr; trap_pc = tpc; trap_vector = tv; ret = r;
    @(posedge clk);
    #1;
    model_step();
  endtask

  task automatic checkOutput(input string tag);
    check({tag, ".pc"}, pc, m_pc);
    check({tag, ".pc_valid"}, {31'b0, pc_valid}, {31'b0, m_active && !m_halted});
    check({tag, ".epc"}, epc, m_epc);
    check({tag, ".misalign"}, {31'b0, misalign}, {31'b0, m_mis});
    check({tag, ".fetch_count"}, fetch_count, m_count);
  endtask

  // Asynchronous reset asserted between clock edges; outputs must clear without a clock.
  task automatic do_reset(input string tag);
    trigger = 0; halt = 0; stall = 0; pc_branch = 0; trap = 0; ret = 0;
    pc_target = 0; trap_pc = 0; trap_vector = TV;
    @(posedge clk);
    #3;
    rst = 1;
    #1;
    model_reset();
    check({tag, ".pc"}, pc, RV);
    check({tag, ".pc_valid"}, {31'b0, pc_valid}, 32'd0);
    check({tag, ".fetch_count"}, fetch_count, 32'd0);
    check({tag, ".epc"}, epc, 32'd0);
    check({tag, ".misalign"}, {31'b0, misalign}, 32'd0);
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  initial begin
    rst = 1;
    trigger = 0; halt = 0; stall = 0; pc_branch = 0; trap = 0; ret = 0;
    pc_target = 0; trap_pc = 0; trap_vector = TV;

    vecs[0]  = '{I,O,O,O,32'h0,O,32'h0,O, RV,               I,32'h0,O,32'd0};
    vecs[1]  = '{I,O,O,O,32'h0,O,32'h0,O, 32'hBFC00004,     I,32'h0,O,32'd1};
    vecs[2]  = '{I,O,O,O,32'h0,O,32'h0,O, 32'hBFC00008,     I,32'h0,O,32'd2};
    vecs[3]  = '{I,O,O,O,32'h0,O,32'h0,O, 32'hBFC0000C,     I,32'h0,O,32'd3};
    vecs[4]  = '{I,O,O,O,32'h0,O,32'h0,O, 32'hBFC00010,     I,32'h0,O,32'd4};
    vecs[5]  = '{I,O,I,I,32'hBFC00100,O,32'h0,O, 32'hBFC00100, I,32'h0,O,32'd5};
    vecs[6]  = '{I,O,I,O,32'h0,O,32'h0,O, 32'hBFC00100,     I,32'h0,O,32'd5};
    vecs[7]  = '{I,O,O,I,32'hBFC00300,I,32'hBFC00008,O, TV, I,32'hBFC00008,O,32'd6};
    vecs[8]  = '{I,O,O,O,32'h0,O,32'h0,O, 32'hBFC00204,     I,32'hBFC00008,O,32'd7};
    vecs[9]  = '{I,O,O,O,32'h0,O,32'h0,I, 32'hBFC00008,     I,32'hBFC00008,O,32'd8};
    vecs[10] = '{I,O,O,I,32'hBFC00102,O,32'h0,O, TV,        I,32'hBFC00102,I,32'd9};
    vecs[11] = '{I,O,O,O,32'h0,O,32'h0,O, 32'hBFC00204,     I,32'hBFC00102,O,32'd10};
    vecs[12] = '{I,I,O,O,32'h0,O,32'h0,O, 32'hBFC00204,     O,32'hBFC00102,O,32'd10};
    vecs[13] = '{I,I,O,I,32'hBFC00400,O,32'h0,O, 32'hBFC00204, O,32'hBFC00102,O,32'd10};
    vecs[14] = '{I,O,O,O,32'h0,O,32'h0,O, 32'hBFC00204,     I,32'hBFC00102,O,32'd10};
    vecs[15] = '{I,O,O,O,32'h0,O,32'h0,O, 32'hBFC00208,     I,32'hBFC00102,O,32'd11};
    vecs[16] = '{I,I,O,O,32'h0,O,32'h0,O, 32'hBFC00208,     O,32'hBFC00102,O,32'd11};
    vecs[17] = '{O,I,O,O,32'h0,O,32'h0,O, RV,               O,32'hBFC00102,O,32'd11};
    vecs[18] = '{O,O,O,I,32'hBFC00500,O,32'h0,O, RV,        O,32'hBFC00102,O,32'd11};
    vecs[19] = '{I,O,O,O,32'h0,O,32'h0,O, RV,               I,32'hBFC00102,O,32'd11};

    do_reset("reset0");

    for (int i = 0; i < 20; i++) begin
      applyStimulus(vecs[i].trigger, vecs[i].halt, vecs[i].stall, vecs[i].pc_branch,
                    vecs[i].pc_target, vecs[i].trap, vecs[i].trap_pc, TV, vecs[i].ret);
      check($sformatf("vec%0d.pc", i), pc, vecs[i].exp_pc);
      check($sformatf("vec%0d.pc_valid", i), {31'b0, pc_valid}, {31'b0, vecs[i].exp_valid});
      check($sformatf("vec%0d.epc", i), epc, vecs[i].exp_epc);
      check($sformatf("vec%0d.misalign", i), {31'b0, misalign}, {31'b0, vecs[i].exp_mis});
      check($sformatf("vec%0d.fetch_count", i), fetch_count, vecs[i].exp_count);
    end

    // Run four free cycles to BFC00010, then reset mid-RUN.
    for (int i = 0; i < 4; i++) applyStimulus(I,O,O,O,32'h0,O,32'h0,TV,O);
    check("midrun.pc", pc, 32'hBFC00010);
    do_reset("reset_midrun");

    // Return with no prior trap lands on the cleared epc.
    applyStimulus(I,O,O,O,32'h0,O,32'h0,TV,O);
    applyStimulus(I,O,O,O,32'h0,O,32'h0,TV,I);
    check("ret_no_trap.pc", pc, 32'h0);
    checkOutput("ret_no_trap");

    // Sequential increment wraps from the top of the address space.
    applyStimulus(I,O,O,I,32'hFFFFFFFC,O,32'h0,TV,O);
    check("wrap_pre.pc", pc, 32'hFFFFFFFC);
    applyStimulus(I,O,O,O,32'h0,O,32'h0,TV,O);
    check("wrap.pc", pc, 32'h0);
    checkOutput("wrap");

    // Trap while halted wakes the sequencer at the handler without counting.
    applyStimulus(I,I,O,O,32'h0,O,32'h0,TV,O);
    applyStimulus(I,I,O,O,32'h0,I,32'h00000044,32'hBFC00800,O);
    check("halt_trap.pc", pc, 32'hBFC00800);
    check("halt_trap.epc", epc, 32'h00000044);
    check("halt_trap.fetch_count", fetch_count, 32'd3);
    checkOutput("halt_trap");

    do_reset("reset_rand");
    for (int n = 0; n < 1500; n++) begin
      logic        tg, h, s, b, tr, r;
      logic [31:0] tgt;
      tg  = ($urandom_range(0, 99) < 95);
      h   = ($urandom_range(0, 99) < 10);
      s   = ($urandom_range(0, 99) < 20);
      b   = ($urandom_range(0, 99) < 20);
      tr  = ($urandom_range(0, 99) < 5);
      r   = ($urandom_range(0, 99) < 5);
      tgt = RV + ($urandom_range(0, 255) << 2);
      if ($urandom_range(0, 3) == 0) tgt = tgt | 32'($urandom_range(1, 3));
      if ($urandom_range(0, 49) == 0) tgt = 32'hFFFFFFF8;
      applyStimulus(tg, h, s, b, tgt, tr, RV + ($urandom_range(0, 63) << 2),
                    TV + ($urandom_range(0, 3) << 4), r);
      checkOutput($sformatf("rand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
